// File: rtl/multdiv_seq_pkg.sv
// Shared definitions for the sequential multiplier/divider,
// its exception encoder and the decode stage.
package multdiv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    localparam int ITER_COUNT = 32;

    localparam logic [4:0] ALU_OP_MUL = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV = 5'b00111;

    localparam logic [2:0] EXC_MUL = 3'd4;
    localparam logic [2:0] EXC_DIV = 3'd5;

endpackage

// File: rtl/md_addsub_33.sv
// Add/subtract shared by the Booth step and the
// restoring-division trial subtraction.
module md_addsub_33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed multiplier (radix-2 Booth) and
// restoring divider with one-cycle ready strobe.
module multdiv_seq
    import multdiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    md_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             q1_q, q1_d;
    logic             neg_q, neg_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             exc_q, exc_d;

    logic             start;
    logic             cnt_done;
    logic             booth_act;
    logic [WIDTH:0]   add_a, add_b, add_s;
    logic [WIDTH:0]   booth_s;
    logic             add_sub;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   p_top;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign cnt_done  = (cnt_q == CNT_W'(ITER_COUNT));
    assign booth_act = lo_q[0] ^ q1_q;
    assign booth_s   = booth_act ? add_s : add_a;
    assign p_top     = {hi_q, lo_q[WIDTH-1]};

    // 0x80000000 maps to itself, read as unsigned 2^31
    assign a_mag = data_operandA[WIDTH-1] ?
                   (~data_operandA + 1'b1) : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ?
                   (~data_operandB + 1'b1) : data_operandB;

    always_comb begin
        add_a   = {hi_q[WIDTH-1], hi_q};
        add_b   = {m_q[WIDTH-1], m_q};
        add_sub = lo_q[0] & ~q1_q;
        if (state_q == ST_DIV) begin
            add_a   = {hi_q, lo_q[WIDTH-1]};
            add_b   = {1'b0, m_q};
            add_sub = 1'b1;
        end
    end

    md_addsub_33 #(
        .W(WIDTH + 1)
    ) u_addsub (
        .a_i  (add_a),
        .b_i  (add_b),
        .sub_i(add_sub),
        .sum_o(add_s)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_MULT) begin
            state_d = ST_MUL;
        end else if (ctrl_DIV) begin
            state_d = ST_DIV;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_MUL:  if (cnt_done) state_d = ST_DONE;
                ST_DIV:  if (dbz_q || cnt_done) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_resultRDY = (state_q == ST_DONE);
        busy           = (state_q == ST_MUL) || (state_q == ST_DIV);
        data_result    = res_q;
        data_exception = exc_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        m_d   = m_q;
        res_d = res_q;
        q1_d  = q1_q;
        neg_d = neg_q;
        dbz_d = dbz_q;
        ovf_d = ovf_q;
        exc_d = exc_q;
        if (start) begin
            cnt_d = '0;
            hi_d  = '0;
            q1_d  = 1'b0;
            res_d = '0;
            exc_d = 1'b0;
            neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dbz_d = (data_operandB == '0);
            ovf_d = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (&data_operandB);
            if (ctrl_MULT) begin
                lo_d = data_operandB;
                m_d  = data_operandA;
            end else begin
                lo_d = a_mag;
                m_d  = b_mag;
            end
        end else begin
            unique case (state_q)
                ST_MUL: begin
                    if (!cnt_done) begin
                        hi_d  = booth_s[WIDTH:1];
                        lo_d  = {booth_s[0], lo_q[WIDTH-1:1]};
                        q1_d  = lo_q[0];
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        res_d = lo_q;
                        exc_d = ~((&p_top) | ~(|p_top));
                    end
                end
                ST_DIV: begin
                    if (dbz_q) begin
                        res_d = '0;
                        exc_d = 1'b1;
                    end else if (!cnt_done) begin
                        if (!add_s[WIDTH]) begin
                            hi_d = add_s[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_d = add_a[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b0};
                        end
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        res_d = neg_q ? (~lo_q + 1'b1) : lo_q;
                        exc_d = ovf_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            res_q <= '0;
            q1_q  <= 1'b0;
            neg_q <= 1'b0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            exc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            res_q <= res_d;
            q1_q  <= q1_d;
            neg_q <= neg_d;
            dbz_q <= dbz_d;
            ovf_q <= ovf_d;
            exc_q <= exc_d;
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq: vector table plus restart,
// reset-abort and simultaneous-start sequences.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] opa, opb;
    logic        mult, div;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    always #5 clock = ~clock;

    multdiv_seq dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_operandA (opa),
        .data_operandB (opb),
        .ctrl_MULT     (mult),
        .ctrl_DIV      (div),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          start;
        int          lat;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h",
                     nm, act, exp);
        end
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (data_resultRDY === 1'b1) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rdy: RDY at cycle %0d, expected none",
                         cyc);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_res"}, data_result, e.res);
                chk({e.name, "_exc"}, 32'(data_exception), 32'(e.exc));
                chk({e.name, "_lat"}, 32'(cyc - e.start), 32'(e.lat));
                chk({e.name, "_busy_rdy"}, 32'(busy), 32'd0);
            end
        end
    end

    task automatic start_op(input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b,
                            input bit push, input exp_t e);
        @(negedge clock);
        opa  = a;
        opb  = b;
        mult = m;
        div  = d;
        if (push) begin
            e.start = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clock);
        #1;
        mult = 1'b0;
        div  = 1'b0;
        opa  = $urandom;
        opb  = $urandom;
        chk({e.name, "_busy_start"}, 32'(busy), 32'd1);
    endtask

    task automatic drain(input string nm);
        int i = 0;
        while (sbq.size() != 0 && i < 80) begin
            @(posedge clock);
            #2;
            i++;
        end
        chk({nm, "_drain_timeout"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    vec_t vt[14];
    exp_t e;

    initial begin
        vt[0]  = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFA,
                   32'hFFFFFFD6, 1'b0, 33};
        vt[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000,
                   32'h00000000, 1'b1, 33};
        // (-1) * INT_MIN = +2^31, which does not fit in 32 bits
        vt[2]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h80000000,
                   32'h80000000, 1'b1, 33};
        vt[3]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000001,
                   32'h7FFFFFFF, 1'b0, 33};
        vt[4]  = '{1'b1, 1'b0, 32'h80000000, 32'h00000001,
                   32'h80000000, 1'b0, 33};
        vt[5]  = '{1'b1, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB,
                   32'h0000000F, 1'b0, 33};
        vt[6]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002,
                   32'hFFFFFFFD, 1'b0, 33};
        vt[7]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF,
                   32'h80000000, 1'b1, 33};
        vt[8]  = '{1'b0, 1'b1, 32'h00000005, 32'h00000000,
                   32'h00000000, 1'b1, 1};
        vt[9]  = '{1'b0, 1'b1, 32'd100, 32'd10,
                   32'd10, 1'b0, 33};
        vt[10] = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE,
                   32'hFFFFFFFD, 1'b0, 33};
        vt[11] = '{1'b0, 1'b1, 32'h80000000, 32'h00000002,
                   32'hC0000000, 1'b0, 33};
        vt[12] = '{1'b0, 1'b1, 32'd3, 32'd7,
                   32'd0, 1'b0, 33};
        vt[13] = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                   32'd14, 1'b0, 33};

        reset_n = 1'b0;
        opa  = '0;
        opb  = '0;
        mult = 1'b0;
        div  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_res", data_result, 32'd0);
        chk("rst_exc", 32'(data_exception), 32'd0);
        chk("rst_rdy", 32'(data_resultRDY), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 14; i++) begin
            e.res  = vt[i].res;
            e.exc  = vt[i].exc;
            e.lat  = vt[i].lat;
            e.name = $sformatf("vec%0d", i);
            start_op(vt[i].m, vt[i].d, vt[i].a, vt[i].b, 1'b1, e);
            drain(e.name);
            @(posedge clock);
        end

        // restart: divide issued 10 edges into a multiply
        e.name = "restart_mul";
        start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, e);
        repeat (9) @(posedge clock);
        e.res  = 32'd14;
        e.exc  = 1'b0;
        e.lat  = 33;
        e.name = "restart_div";
        start_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, e);
        drain(e.name);
        repeat (40) @(posedge clock);

        // async reset in the middle of a multiply
        e.name = "rst_mul";
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFA, 1'b0, e);
        repeat (19) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_res", data_result, 32'd0);
        chk("midrst_exc", 32'(data_exception), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdy", 32'(data_resultRDY), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(posedge clock);

        e.res  = 32'd18;
        e.exc  = 1'b0;
        e.lat  = 33;
        e.name = "both_start";
        start_op(1'b1, 1'b1, 32'd6, 32'd3, 1'b1, e);
        drain(e.name);
        repeat (5) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
